// File: rtl/mprj_wb_mailbox_if.sv
// Wishbone classic bus bundle for the user-project mailbox responder.
interface mprj_wb_mailbox_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      output wb_ack_o, wb_dat_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      input  wb_ack_o, wb_dat_o
   );
endinterface

// File: rtl/mprj_wb_mailbox.sv
// Wishbone mailbox responder: C2U and U2C FIFOs, STATUS with sticky error flags,
// IRQ_EN mask, registered ack after WAIT_STATES extra cycles, level interrupt.
module mprj_wb_mailbox #(
   parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter int          WAIT_STATES = 0
) (
   input  logic               core_clk,
   input  logic               core_rstn,
   mprj_wb_mailbox_if.slave   wb,
   // User side: a word moves when en is high and valid/ready is high in the same cycle;
   // rd_en with valid low and wr_en with ready low never move data.
   output logic               usr_rd_valid,
   output logic [31:0]        usr_rd_data,
   input  logic               usr_rd_en,
   input  logic               usr_wr_en,
   input  logic [31:0]        usr_wr_data,
   output logic               usr_wr_ready,
   output logic               irq_o,
   output logic [1:0]         dbg_state_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [3:0]    WS_LAST  = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic            we_q;
   logic [3:0]      sel_q;
   logic [5:0]      off_q;
   logic [31:0]     dat_q;
   logic [2:0]      flags_q, flags_d;
   logic [2:0]      irq_en_q, irq_en_d;
   logic            irq_q, irq_d;
   logic [CW-1:0]   c2u_cnt_q, c2u_cnt_d, u2c_cnt_q, u2c_cnt_d;
   logic [AW-1:0]   c2u_wp_q, c2u_rp_q, u2c_wp_q, u2c_rp_q;
   logic [31:0]     c2u_mem [FIFO_DEPTH];
   logic [31:0]     u2c_mem [FIFO_DEPTH];

   logic hit, start, in_ack;
   logic wr_tx, rd_rx, wr_st, wr_ie;
   logic c2u_full, c2u_empty, u2c_full, u2c_empty;
   logic c2u_push, c2u_pop, u2c_push, u2c_pop;
   logic [31:0] tx_word, status, rd_mux;
   logic unused_adr;

   assign unused_adr = ^wb.wb_adr_i[1:0];
   assign hit        = wb.wb_adr_i[31:8] == BASE_ADR[31:8];

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      start   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wb.wb_cyc_i && wb.wb_stb_i && hit) begin
               start   = 1'b1;
               wcnt_d  = 4'd0;
               state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!wb.wb_cyc_i)          state_d = S_IDLE;
            else if (wcnt_q == WS_LAST) state_d = S_ACK;
            else                        wcnt_d  = wcnt_q + 4'd1;
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ack = state_q == S_ACK;
   assign wr_tx  = in_ack &&  we_q && off_q == 6'd0;
   assign rd_rx  = in_ack && !we_q && off_q == 6'd1;
   assign wr_st  = in_ack &&  we_q && off_q == 6'd2 && sel_q[0];
   assign wr_ie  = in_ack &&  we_q && off_q == 6'd3 && sel_q[0];

   assign c2u_full  = c2u_cnt_q == FULL_CNT;
   assign c2u_empty = c2u_cnt_q == '0;
   assign u2c_full  = u2c_cnt_q == FULL_CNT;
   assign u2c_empty = u2c_cnt_q == '0;

   // Full/empty are judged on the pre-cycle counts, so a same-cycle pop never rescues a push.
   assign c2u_push = wr_tx && !c2u_full;
   assign c2u_pop  = usr_rd_en && !c2u_empty;
   assign u2c_push = usr_wr_en && !u2c_full;
   assign u2c_pop  = rd_rx && !u2c_empty;

   assign tx_word = {sel_q[3] ? dat_q[31:24] : 8'h00, sel_q[2] ? dat_q[23:16] : 8'h00,
                     sel_q[1] ? dat_q[15:8]  : 8'h00, sel_q[0] ? dat_q[7:0]   : 8'h00};
   assign status  = {8'h00, 8'(u2c_cnt_q), 8'(c2u_cnt_q), 1'b0, flags_q,
                     u2c_full, u2c_empty, c2u_full, c2u_empty};

   always_comb begin
      c2u_cnt_d = c2u_cnt_q + CW'(c2u_push) - CW'(c2u_pop);
      u2c_cnt_d = u2c_cnt_q + CW'(u2c_push) - CW'(u2c_pop);
      // flags: [0] C2U_OVF, [1] UDF, [2] U2C_OVF; a set in the clearing cycle wins.
      flags_d   = (flags_q & ~(wr_st ? dat_q[6:4] : 3'b000)) |
                  {usr_wr_en && u2c_full, rd_rx && u2c_empty, wr_tx && c2u_full};
      irq_en_d  = wr_ie ? dat_q[2:0] : irq_en_q;
      irq_d     = |(irq_en_q & {|flags_q, !u2c_empty, c2u_empty});
      case (off_q)
         6'd1:    rd_mux = u2c_empty ? 32'h0 : u2c_mem[u2c_rp_q];
         6'd2:    rd_mux = status;
         6'd3:    rd_mux = {29'h0, irq_en_q};
         default: rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         state_q   <= S_IDLE;
         wcnt_q    <= 4'd0;
         we_q      <= 1'b0;
         sel_q     <= 4'd0;
         off_q     <= 6'd0;
         dat_q     <= 32'h0;
         flags_q   <= 3'b000;
         irq_en_q  <= 3'b000;
         irq_q     <= 1'b0;
         c2u_cnt_q <= '0;
         u2c_cnt_q <= '0;
         c2u_wp_q  <= '0;
         c2u_rp_q  <= '0;
         u2c_wp_q  <= '0;
         u2c_rp_q  <= '0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         if (start) begin
            we_q  <= wb.wb_we_i;
            sel_q <= wb.wb_sel_i;
            off_q <= wb.wb_adr_i[7:2];
            dat_q <= wb.wb_dat_i;
         end
         flags_q   <= flags_d;
         irq_en_q  <= irq_en_d;
         irq_q     <= irq_d;
         c2u_cnt_q <= c2u_cnt_d;
         u2c_cnt_q <= u2c_cnt_d;
         if (c2u_push) c2u_wp_q <= c2u_wp_q + 1'b1;
         if (c2u_pop)  c2u_rp_q <= c2u_rp_q + 1'b1;
         if (u2c_push) u2c_wp_q <= u2c_wp_q + 1'b1;
         if (u2c_pop)  u2c_rp_q <= u2c_rp_q + 1'b1;
      end
   end

   always_ff @(posedge core_clk) begin
      if (c2u_push) c2u_mem[c2u_wp_q] <= tx_word;
      if (u2c_push) u2c_mem[u2c_wp_q] <= usr_wr_data;
   end

   assign wb.wb_ack_o  = in_ack;
   assign wb.wb_dat_o  = (in_ack && !we_q) ? rd_mux : 32'h0;
   assign usr_rd_valid = !c2u_empty;
   assign usr_rd_data  = c2u_mem[c2u_rp_q];
   assign usr_wr_ready = !u2c_full;
   assign irq_o        = irq_q;
   assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_mprj_wb_mailbox.sv
// Directed bench for mprj_wb_mailbox: a zero-wait-state instance for function
// and a three-wait-state instance for latency, aborted cycles and address misses.
module tb_mprj_wb_mailbox;
   localparam logic [31:0] A_TX = 32'h3000_0000;
   localparam logic [31:0] A_RX = 32'h3000_0004;
   localparam logic [31:0] A_ST = 32'h3000_0008;
   localparam logic [31:0] A_IE = 32'h3000_000C;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mprj_wb_mailbox_if bus0();
   mprj_wb_mailbox_if bus3();

   logic        rd_valid0, rd_en0, wr_en0, wr_ready0, irq0;
   logic [31:0] rd_data0, wr_data0;
   logic [1:0]  dbg0;
   logic        rd_valid3, rd_en3, wr_en3, wr_ready3, irq3;
   logic [31:0] rd_data3, wr_data3;
   logic [1:0]  dbg3;

   mprj_wb_mailbox #(.WAIT_STATES(0)) dut0 (
      .core_clk(clk), .core_rstn(rst_n), .wb(bus0.slave),
      .usr_rd_valid(rd_valid0), .usr_rd_data(rd_data0), .usr_rd_en(rd_en0),
      .usr_wr_en(wr_en0), .usr_wr_data(wr_data0), .usr_wr_ready(wr_ready0),
      .irq_o(irq0), .dbg_state_o(dbg0));

   mprj_wb_mailbox #(.WAIT_STATES(3)) dut3 (
      .core_clk(clk), .core_rstn(rst_n), .wb(bus3.slave),
      .usr_rd_valid(rd_valid3), .usr_rd_data(rd_data3), .usr_rd_en(rd_en3),
      .usr_wr_en(wr_en3), .usr_wr_data(wr_data3), .usr_wr_ready(wr_ready3),
      .irq_o(irq3), .dbg_state_o(dbg3));

   int n_pass = 0;
   int n_total = 0;
   logic [31:0] rdat;
   int lat;

   task automatic drive(input bit d3, input bit cyc, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
      if (d3) begin
         bus3.wb_cyc_i = cyc; bus3.wb_stb_i = cyc; bus3.wb_we_i = we;
         bus3.wb_adr_i = adr; bus3.wb_dat_i = dat; bus3.wb_sel_i = sel;
      end else begin
         bus0.wb_cyc_i = cyc; bus0.wb_stb_i = cyc; bus0.wb_we_i = we;
         bus0.wb_adr_i = adr; bus0.wb_dat_i = dat; bus0.wb_sel_i = sel;
      end
   endtask

   function automatic logic get_ack(input bit d3);
      return d3 ? bus3.wb_ack_o : bus0.wb_ack_o;
   endfunction

   // One transfer; lat = posedges from request to ack, -1 if no ack within 20 cycles.
   // Returns at the falling edge inside the ack cycle.
   task automatic xfer(input bit d3, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rd, output int l);
      int n;
      bit got;
      @(posedge clk); #1;
      drive(d3, 1'b1, we, adr, dat, sel);
      n = 0; got = 0; rd = 32'h0;
      while (n < 20 && !got) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (get_ack(d3)) begin
            got = 1;
            rd = d3 ? bus3.wb_dat_o : bus0.wb_dat_o;
         end
      end
      l = got ? n : -1;
      drive(d3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({bus0.wb_ack_o, bus3.wb_ack_o, irq0, irq3, rd_valid0, wr_ready0} !== 6'b000001)
         $display("FAIL reset_outputs: got %b want 000001",
                  {bus0.wb_ack_o, bus3.wb_ack_o, irq0, irq3, rd_valid0, wr_ready0});
      else n_pass++;
      n_total++;
      if (bus0.wb_dat_o !== 32'h0 || dbg0 !== 2'd0)
         $display("FAIL reset_dat: dat=%h state=%0d want 0/0", bus0.wb_dat_o, dbg0);
      else n_pass++;
      rst_n = 1'b1;
      xfer(0, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (lat !== 1 || rdat !== 32'h0000_0005 || irq0 !== 1'b0)
         $display("FAIL reset_status: lat=%0d dat=%h irq=%b want 1/00000005/0", lat, rdat, irq0);
      else n_pass++;
   endtask

   task automatic test_tx_sel();
      xfer(0, 1, A_TX, 32'hA5A5_1234, 4'b0011, rdat, lat);
      @(posedge clk); #1;
      n_total++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h0000_1234)
         $display("FAIL tx_sel: valid=%b data=%h want 1/00001234", rd_valid0, rd_data0);
      else n_pass++;
      xfer(0, 0, A_TX, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0) $display("FAIL tx_read: got %h want 0", rdat);
      else n_pass++;
      @(posedge clk); #1 rd_en0 = 1'b1;
      @(posedge clk); #1 rd_en0 = 1'b0;
      n_total++;
      if (rd_valid0 !== 1'b0) $display("FAIL tx_pop: valid=%b want 0", rd_valid0);
      else n_pass++;
   endtask

   task automatic test_c2u_overflow();
      for (int i = 0; i < 9; i++) xfer(0, 1, A_TX, 32'h1000_0000 + i, 4'hF, rdat, lat);
      xfer(0, 0, A_ST, 0, 4'hF, rdat, lat);
      // c2u full + C2U_OVF + count 8, and U2C still empty (bit 2)
      n_total++;
      if (rdat !== 32'h0000_0816) $display("FAIL c2u_ovf_status: got %h want 00000816", rdat);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (rd_data0 !== 32'h1000_0000 + i)
            $display("FAIL c2u_drain_%0d: got %h want %h", i, rd_data0, 32'h1000_0000 + i);
         else n_pass++;
         rd_en0 = 1'b1;
         @(posedge clk); #1 rd_en0 = 1'b0;
      end
      n_total++;
      if (rd_valid0 !== 1'b0) $display("FAIL c2u_ninth_absent: valid=%b want 0", rd_valid0);
      else n_pass++;
      xfer(0, 1, A_ST, 32'h10, 4'b0001, rdat, lat);
      xfer(0, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0000_0005) $display("FAIL c2u_ovf_clear: got %h want 00000005", rdat);
      else n_pass++;
   endtask

   task automatic test_udf();
      xfer(0, 0, A_RX, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0) $display("FAIL udf_data: got %h want 0", rdat);
      else n_pass++;
      xfer(0, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0000_0025) $display("FAIL udf_status: got %h want 00000025", rdat);
      else n_pass++;
      xfer(0, 1, A_ST, 32'h20, 4'b0001, rdat, lat);
      xfer(0, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0000_0005) $display("FAIL udf_clear: got %h want 00000005", rdat);
      else n_pass++;
   endtask

   task automatic test_irq();
      xfer(0, 1, A_IE, 32'h2, 4'b0001, rdat, lat);
      xfer(0, 0, A_IE, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h2 || irq0 !== 1'b0)
         $display("FAIL irq_en_rd: dat=%h irq=%b want 2/0", rdat, irq0);
      else n_pass++;
      @(posedge clk); #1 wr_en0 = 1'b1; wr_data0 = 32'hCAFE_F00D;
      @(posedge clk); #1 wr_en0 = 1'b0;
      n_total++;
      if (irq0 !== 1'b0) $display("FAIL irq_not_early: irq=%b want 0", irq0);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (irq0 !== 1'b1) $display("FAIL irq_rise: irq=%b want 1", irq0);
      else n_pass++;
      xfer(0, 0, A_RX, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'hCAFE_F00D) $display("FAIL irq_rx_data: got %h want cafef00d", rdat);
      else n_pass++;
      @(posedge clk); @(posedge clk); #1;
      n_total++;
      if (irq0 !== 1'b0) $display("FAIL irq_fall: irq=%b want 0", irq0);
      else n_pass++;
      xfer(0, 1, A_IE, 32'h0, 4'b0001, rdat, lat);
   endtask

   task automatic test_u2c_overflow();
      @(posedge clk); #1 wr_en0 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wr_data0 = 32'h2000_0000 + i;
         @(posedge clk); #1;
      end
      wr_en0 = 1'b0;
      n_total++;
      if (wr_ready0 !== 1'b0) $display("FAIL u2c_ready: got %b want 0", wr_ready0);
      else n_pass++;
      xfer(0, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0008_0049) $display("FAIL u2c_ovf_status: got %h want 00080049", rdat);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         xfer(0, 0, A_RX, 0, 4'hF, rdat, lat);
         n_total++;
         if (rdat !== 32'h2000_0000 + i)
            $display("FAIL u2c_drain_%0d: got %h want %h", i, rdat, 32'h2000_0000 + i);
         else n_pass++;
      end
      xfer(0, 1, A_ST, 32'h40, 4'b0001, rdat, lat);
      xfer(0, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0000_0005) $display("FAIL u2c_ovf_clear: got %h want 00000005", rdat);
      else n_pass++;
   endtask

   task automatic test_simul();
      xfer(0, 1, A_TX, 32'h1111_1111, 4'hF, rdat, lat);
      xfer(0, 1, A_TX, 32'h2222_2222, 4'hF, rdat, lat);
      rd_en0 = 1'b1;
      @(posedge clk); #1 rd_en0 = 1'b0;
      n_total++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h2222_2222)
         $display("FAIL simul_head: valid=%b data=%h want 1/22222222", rd_valid0, rd_data0);
      else n_pass++;
      xfer(0, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0000_0104) $display("FAIL simul_count: got %h want 00000104", rdat);
      else n_pass++;
      @(posedge clk); #1 rd_en0 = 1'b1;
      @(posedge clk); #1 rd_en0 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] acks;
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b1, A_TX, 32'h3333_0000, 4'hF);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         acks[k] = bus0.wb_ack_o;
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      n_total++;
      if (acks !== 4'b0101) $display("FAIL b2b_acks: got %b want 0101", acks);
      else n_pass++;
      xfer(0, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0000_0204) $display("FAIL b2b_count: got %h want 00000204", rdat);
      else n_pass++;
      @(posedge clk); #1 rd_en0 = 1'b1;
      @(posedge clk); @(posedge clk); #1 rd_en0 = 1'b0;
   endtask

   task automatic test_wait_states();
      int acks;
      xfer(1, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (lat !== 4 || rdat !== 32'h0000_0005)
         $display("FAIL ws3_latency: lat=%0d dat=%h want 4/00000005", lat, rdat);
      else n_pass++;
      @(posedge clk); #1 wr_en3 = 1'b1; wr_data3 = 32'hBEEF_0001;
      @(posedge clk); #1 wr_en3 = 1'b0;
      drive(1, 1'b1, 1'b0, A_RX, 32'h0, 4'hF);
      @(posedge clk); @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      acks = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus3.wb_ack_o) acks++;
      end
      n_total++;
      if (acks !== 0) $display("FAIL ws3_abort_ack: got %0d acks want 0", acks);
      else n_pass++;
      xfer(1, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0001_0001) $display("FAIL ws3_abort_nopop: got %h want 00010001", rdat);
      else n_pass++;
      xfer(1, 0, A_RX, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'hBEEF_0001) $display("FAIL ws3_rx: got %h want beef0001", rdat);
      else n_pass++;
      xfer(1, 0, 32'h3000_0100, 0, 4'hF, rdat, lat);
      n_total++;
      if (lat !== -1) $display("FAIL ws3_miss: lat=%0d want -1 (no ack)", lat);
      else n_pass++;
      xfer(0, 1, 32'h2FFF_FF00, 32'h1, 4'hF, rdat, lat);
      n_total++;
      if (lat !== -1 || rd_valid0 !== 1'b0)
         $display("FAIL ws0_miss: lat=%0d valid=%b want -1/0", lat, rd_valid0);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      xfer(0, 1, A_IE, 32'h1, 4'b0001, rdat, lat);
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b1, A_TX, 32'h4444_4444, 4'hF);
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (bus0.wb_ack_o !== 1'b1 || irq0 !== 1'b1)
         $display("FAIL mid_pre: ack=%b irq=%b want 1/1", bus0.wb_ack_o, irq0);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (bus0.wb_ack_o !== 1'b0 || irq0 !== 1'b0)
         $display("FAIL mid_async: ack=%b irq=%b want 0/0", bus0.wb_ack_o, irq0);
      else n_pass++;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      xfer(0, 0, A_ST, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0000_0005 || rd_valid0 !== 1'b0)
         $display("FAIL mid_nopush: status=%h valid=%b want 00000005/0", rdat, rd_valid0);
      else n_pass++;
      xfer(0, 0, A_IE, 0, 4'hF, rdat, lat);
      n_total++;
      if (rdat !== 32'h0) $display("FAIL mid_ie_cleared: got %h want 0", rdat);
      else n_pass++;
   endtask

   initial begin
      rd_en0 = 0; wr_en0 = 0; wr_data0 = 0;
      rd_en3 = 0; wr_en3 = 0; wr_data3 = 0;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      test_reset();
      test_tx_sel();
      test_c2u_overflow();
      test_udf();
      test_irq();
      test_u2c_overflow();
      test_simul();
      test_back_to_back();
      test_wait_states();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
